// File: rtl/seq_digit_comparator.sv
// seq_digit_comparator: digit-serial MSB-first magnitude comparator with start/done handshake and signed mode
module seq_digit_comparator #(
    parameter int W = 16,
    parameter int D = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         EQ,
    output logic         GT,
    output logic         LT
);
    localparam int N = W / D;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [W-1:0] sa, sb;
    logic [CW-1:0] cnt;
    logic eq_acc, gt_acc, eq_nx, gt_nx, fin;
    logic [D-1:0] da, db;
    always_comb begin
        da = sa[W-1 -: D];
        db = sb[W-1 -: D];
        eq_nx = eq_acc ? (da == db) : eq_acc;
        gt_nx = eq_acc ? (da > db) : gt_acc;
        fin = state == RUN && (cnt == CW'(N - 1) || (EARLY_EXIT != 0 && eq_acc && da != db));
        state_nx = state == IDLE ? (start ? RUN : IDLE) : (fin ? IDLE : RUN);
    end
    assign busy = state == RUN;
    // flipping both MSBs in signed mode lets the unsigned digit cascade order two's complement values
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done <= 1'b0;
            EQ <= 1'b0;
            GT <= 1'b0;
            LT <= 1'b0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            done <= fin;
            if (state == IDLE && start) begin
                sa <= a ^ (W'(signed_mode) << (W - 1));
                sb <= b ^ (W'(signed_mode) << (W - 1));
                eq_acc <= 1'b1;
                gt_acc <= 1'b0;
                cnt <= '0;
            end else if (state == RUN) begin
                sa <= sa << D;
                sb <= sb << D;
                eq_acc <= eq_nx;
                gt_acc <= gt_nx;
                cnt <= cnt + 1'b1;
            end
            if (fin) begin
                EQ <= eq_nx;
                GT <= gt_nx;
                LT <= ~eq_nx & ~gt_nx;
            end
        end
    end
endmodule

// File: tb/tb_seq_digit_comparator.sv
// tb_seq_digit_comparator: scoreboard bench over four configurations (W8/D2 and W16/D4, early exit on/off)
module tb_seq_digit_comparator;
    typedef struct {
        logic [2:0] res;
        int lat;
    } exp_t;
    logic clk, rst, sm;
    logic [15:0] a, b;
    logic [3:0] st, busy, done, eq, gt, lt;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;

    seq_digit_comparator #(.W(8), .D(2), .EARLY_EXIT(1)) u0 (.clk(clk), .rst(rst), .start(st[0]), .signed_mode(sm),
        .a(a[7:0]), .b(b[7:0]), .busy(busy[0]), .done(done[0]), .EQ(eq[0]), .GT(gt[0]), .LT(lt[0]));
    seq_digit_comparator #(.W(8), .D(2), .EARLY_EXIT(0)) u1 (.clk(clk), .rst(rst), .start(st[1]), .signed_mode(sm),
        .a(a[7:0]), .b(b[7:0]), .busy(busy[1]), .done(done[1]), .EQ(eq[1]), .GT(gt[1]), .LT(lt[1]));
    seq_digit_comparator #(.W(16), .D(4), .EARLY_EXIT(1)) u2 (.clk(clk), .rst(rst), .start(st[2]), .signed_mode(sm),
        .a(a), .b(b), .busy(busy[2]), .done(done[2]), .EQ(eq[2]), .GT(gt[2]), .LT(lt[2]));
    seq_digit_comparator #(.W(16), .D(4), .EARLY_EXIT(0)) u3 (.clk(clk), .rst(rst), .start(st[3]), .signed_mode(sm),
        .a(a), .b(b), .busy(busy[3]), .done(done[3]), .EQ(eq[3]), .GT(gt[3]), .LT(lt[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(int i, bit s, logic [15:0] av, logic [15:0] bv);
        int w = i < 2 ? 8 : 16;
        int d = i < 2 ? 2 : 4;
        int n = w / d;
        int ua = int'(av) & ((1 << w) - 1);
        int ub = int'(bv) & ((1 << w) - 1);
        int ai = ua, bi = ub;
        exp_t e;
        if (s && ai >= (1 << (w - 1))) ai -= 1 << w;
        if (s && bi >= (1 << (w - 1))) bi -= 1 << w;
        e.res = ai == bi ? 3'b100 : ai > bi ? 3'b010 : 3'b001;
        e.lat = n;
        if (i % 2 == 0)
            for (int j = 0; j < n; j++)
                if (((ua >> (w - d * (j + 1))) & ((1 << d) - 1)) != ((ub >> (w - d * (j + 1))) & ((1 << d) - 1))) begin
                    e.lat = j + 1;
                    break;
                end
        return e;
    endfunction

    task automatic go(int i, bit s, logic [15:0] av, logic [15:0] bv);
        a = av;
        b = bv;
        sm = s;
        sb.push_back(model(i, s, av, bv));
        st[i] = 1'b1;
    endtask

    task automatic wait_done(int i, bit inj);
        exp_t e;
        int cyc = 0;
        @(posedge clk);
        @(negedge clk);
        st[i] = 1'b0;
        check("busy_after_start", 32'(busy[i]), 1);
        check("done_after_start", 32'(done[i]), 0);
        while (!done[i] && cyc < 20) begin
            if (inj && cyc == 1) begin
                a = 16'hFFFF;
                b = 16'h0000;
                sm = ~sm;
                st[i] = 1'b1;
            end else st[i] = 1'b0;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        st[i] = 1'b0;
        e = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.lat));
        check("result", 32'({eq[i], gt[i], lt[i]}), 32'(e.res));
        check("busy_at_done", 32'(busy[i]), 0);
    endtask

    initial begin
        rst = 1'b1;
        st = '0;
        a = '0;
        b = '0;
        sm = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({busy, done, eq, gt, lt}), 0);
        rst = 1'b0;
        @(negedge clk);
        go(0, 0, 16'h00A5, 16'h00A5); wait_done(0, 0);
        go(0, 0, 16'h0080, 16'h007F); wait_done(0, 0);
        go(0, 1, 16'h0080, 16'h007F); wait_done(0, 0);
        go(0, 0, 16'h0034, 16'h0035); wait_done(0, 0);
        go(1, 0, 16'h00C0, 16'h0000); wait_done(1, 0);
        go(1, 1, 16'h00C0, 16'h0000); wait_done(1, 0);
        go(0, 0, 16'h0001, 16'h0002); wait_done(0, 1);
        go(0, 0, 16'h00A5, 16'h00A5); wait_done(0, 0);
        a = 16'h0001;
        b = 16'h0002;
        sm = 1'b0;
        st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_run_reset", 32'({busy[0], done[0], eq[0], gt[0], lt[0]}), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("no_done_after_reset", 32'(done[0]), 0);
        end
        go(0, 0, 16'h0001, 16'h0002); wait_done(0, 0);
        for (int n = 0; n < 10000; n++) begin
            int i = 2 + (n & 1);
            logic [15:0] av = 16'($urandom), bv = 16'($urandom);
            int r = int'($urandom_range(0, 3));
            if (r == 0) bv = av;
            else if (r == 1) bv = av ^ (16'($urandom) & 16'h00FF);
            go(i, 1'($urandom), av, bv);
            wait_done(i, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
